// File: rtl/td4x_if.sv
// td4x_if: instruction-fetch bus between the td4x core (master) and instruction memory (slave).
interface td4x_if #(parameter int DW = 4, parameter int AW = 4);
    logic [AW-1:0]   imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [DW+3:0]   imem_data;
    modport master (output imem_addr, output imem_req, input imem_ack, input imem_data);
    modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/td4x_core.sv
// td4x_core: TD4-style 4-bit CPU with fetch/execute/halt FSM, two registers, carry flag and output port.
module td4x_core #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    td4x_if.master        bus,
    input  logic [DW-1:0] inp,
    output logic [DW-1:0] outp,
    output logic          out_valid,
    output logic          halted,
    output logic          cflag
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_a, r_b, r_out;
    logic [DW+3:0] r_ir;
    logic          r_c, r_ov;
    logic [3:0]    w_op;
    logic [DW-1:0] w_imm;
    logic [DW:0]   w_sum_a, w_sum_b;
    logic          w_taken;

    always_comb begin
        w_op    = r_ir[DW+3:DW];
        w_imm   = r_ir[DW-1:0];
        w_sum_a = {1'b0, r_a} + {1'b0, w_imm};
        w_sum_b = {1'b0, r_b} + {1'b0, w_imm};
        w_taken = (w_op == 4'b1111) || (w_op == 4'b1110 && !r_c) || (w_op == 4'b1100 && r_c);
    end

    assign bus.imem_req  = (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign outp      = r_out;
    assign out_valid = r_ov;
    assign halted    = (r_state == S_HALT);
    assign cflag     = r_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ir    <= '0;
            r_c     <= 1'b0;
            r_out   <= '0;
            r_ov    <= 1'b0;
        end else begin
            r_ov <= 1'b0;
            case (r_state)
                S_FETCH: if (bus.imem_ack) begin
                    r_ir    <= bus.imem_data;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // Only the two ADD opcodes leave a carry behind; they override this clear below.
                    r_c     <= 1'b0;
                    r_pc    <= w_taken ? w_imm[AW-1:0] : r_pc + 1'b1;
                    r_state <= (w_op == 4'b1000) ? S_HALT : S_FETCH;
                    case (w_op)
                        4'b0000: {r_c, r_a} <= w_sum_a;
                        4'b0001: r_a <= r_b;
                        4'b0010: r_a <= inp;
                        4'b0011: r_a <= w_imm;
                        4'b0100: r_b <= r_a;
                        4'b0101: {r_c, r_b} <= w_sum_b;
                        4'b0110: r_b <= inp;
                        4'b0111: r_b <= w_imm;
                        4'b1001: begin r_out <= r_b;   r_ov <= 1'b1; end
                        4'b1010: begin r_out <= r_a;   r_ov <= 1'b1; end
                        4'b1011: begin r_out <= w_imm; r_ov <= 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_td4x_core.sv
// tb_td4x_core: directed programs with a scoreboard queue of expected output-port values.
module tb_td4x_core;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ack_en = 1'b1;
    logic [3:0] inp = 4'd0;
    logic [3:0] outp;
    logic       out_valid, halted, cflag;
    logic [7:0] mem [16];
    logic [3:0] exp_q [$];
    logic       prev_ov = 1'b0;
    int         checks = 0;
    int         failures = 0;

    td4x_if #(.DW(4), .AW(4)) bus ();
    assign bus.imem_ack  = ack_en;
    assign bus.imem_data = mem[bus.imem_addr];

    td4x_core #(.DW(4), .AW(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .inp(inp),
        .outp(outp), .out_valid(out_valid), .halted(halted), .cflag(cflag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            chk("out_valid_single_cycle", int'(prev_ov), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out got=%0d expected=none", outp);
            end else begin
                chk("outp", int'(outp), int'(exp_q.pop_front()));
            end
        end
        prev_ov = out_valid && !reset;
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'hD0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halted"}, int'(halted), 1);
        @(negedge clk);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_fetch(input logic [3:0] a, input string name);
        int n;
        n = 0;
        while (!(bus.imem_req && bus.imem_addr == a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_fetch_reached"}, int'(bus.imem_req && bus.imem_addr == a), 1);
    endtask

    initial begin
        clear_mem();
        #1;
        chk("rst_outp", int'(outp), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_cflag", int'(cflag), 0);

        // A=3, A+=5 -> 8, out A, halt; ack held high throughout
        mem[0] = 8'b0011_0011; mem[1] = 8'b0000_0101; mem[2] = 8'b1010_0000; mem[3] = 8'b1000_0000;
        exp_q.push_back(4'd8);
        do_reset();
        chk("first_req", int'(bus.imem_req), 1);
        chk("first_addr", int'(bus.imem_addr), 0);
        run_to_halt("prog_sum");
        chk("prog_sum_cflag", int'(cflag), 0);
        chk("prog_sum_req_in_halt", int'(bus.imem_req), 0);

        // carry out of A=15+1, then JNC not taken
        clear_mem();
        mem[0] = 8'b0011_1111; mem[1] = 8'b0000_0001; mem[2] = 8'b1110_0111;
        mem[3] = 8'b1010_0000; mem[4] = 8'b1000_0000; mem[7] = 8'b1011_0101;
        exp_q.push_back(4'd0);
        do_reset();
        wait_fetch(4'd2, "jnc");
        chk("add_carry_set", int'(cflag), 1);
        @(negedge clk);
        @(negedge clk);
        chk("jnc_not_taken_addr", int'(bus.imem_addr), 3);
        chk("jnc_clears_cflag", int'(cflag), 0);
        run_to_halt("prog_jnc");

        // fetch stalled five cycles without acknowledge
        clear_mem();
        mem[0] = 8'b0011_0101; mem[1] = 8'b1010_0000; mem[2] = 8'b1000_0000;
        exp_q.push_back(4'd5);
        ack_en = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", int'(bus.imem_req), 1);
            chk("stall_addr", int'(bus.imem_addr), 0);
            @(negedge clk);
        end
        ack_en = 1'b1;
        @(negedge clk);
        chk("exec_after_ack_req", int'(bus.imem_req), 0);
        run_to_halt("prog_stall");

        // PC wraps from 15 to 0 after a NOP
        clear_mem();
        mem[0] = 8'b1111_1111; mem[15] = 8'b1101_0000;
        do_reset();
        wait_fetch(4'd15, "wrap");
        @(negedge clk);
        @(negedge clk);
        chk("wrap_req", int'(bus.imem_req), 1);
        chk("wrap_addr", int'(bus.imem_addr), 0);

        // register moves, B add with carry, taken JC, all three output sources
        clear_mem();
        inp = 4'b1010;
        mem[0]  = 8'b0110_0000; mem[1]  = 8'b1001_0000; mem[2]  = 8'b0111_1001;
        mem[3]  = 8'b0101_1000; mem[4]  = 8'b1100_0110; mem[5]  = 8'b1011_1111;
        mem[6]  = 8'b0001_0000; mem[7]  = 8'b0000_0010; mem[8]  = 8'b0100_0000;
        mem[9]  = 8'b1001_0000; mem[10] = 8'b0010_0000; mem[11] = 8'b1010_0000;
        mem[12] = 8'b1011_0110; mem[13] = 8'b1000_0000;
        exp_q.push_back(4'd10); exp_q.push_back(4'd3);
        exp_q.push_back(4'd10); exp_q.push_back(4'd6);
        do_reset();
        wait_fetch(4'd4, "jc");
        chk("addb_carry_set", int'(cflag), 1);
        run_to_halt("prog_regs");

        // asynchronous reset in the middle of an EXEC cycle
        clear_mem();
        mem[0] = 8'b0011_0101; mem[1] = 8'b1011_0011; mem[2] = 8'b0000_0001; mem[3] = 8'b1000_0000;
        exp_q.push_back(4'd3);
        do_reset();
        wait_fetch(4'd2, "async");
        @(posedge clk);
        #2;
        chk("pre_async_outp", int'(outp), 3);
        chk("pre_async_in_exec", int'(bus.imem_req), 0);
        reset = 1'b1;
        #1;
        chk("async_outp", int'(outp), 0);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_halted", int'(halted), 0);
        chk("async_cflag", int'(cflag), 0);
        chk("async_req", int'(bus.imem_req), 1);
        chk("async_addr", int'(bus.imem_addr), 0);
        chk("async_queue_drained", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/td4x_core.md
TD4X_CORE -- requirements
Module: td4x_core

Interface
REQ-001 Parameter DW, default 4: data width of registers A, B, output port, input port and immediate field.
REQ-002 Parameter AW, default 4: program counter and instruction-address width; legal range 1 <= AW <= DW.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  AW  instruction fetch address (current PC).
REQ-006 imem_req  output  1  fetch request.
REQ-007 imem_ack  input  1  fetch acknowledge; imem_data valid in the same cycle.
REQ-008 imem_data  input  4+DW  instruction: bits [DW+3:DW] opcode, bits [DW-1:0] immediate.
REQ-009 inp  input  DW  external input port.
REQ-010 outp  output  DW  registered output port.
REQ-011 out_valid  output  1  one-cycle pulse when outp is written.
REQ-012 halted  output  1  high while the core is in HALT.
REQ-013 cflag  output  1  current carry flag.

Function
REQ-014 FSM states: FETCH, EXEC, HALT; reset state is FETCH.
REQ-015 FETCH: imem_req=1, imem_addr=PC held stable; on a clk edge with imem_ack=1, latch imem_data into IR and go to EXEC; otherwise stay in FETCH.
REQ-016 EXEC: imem_req=0; execute IR in exactly one cycle, then go to FETCH (or HALT for opcode 1000).
REQ-017 Minimum throughput: 2 cycles per instruction with zero-wait acknowledge.
REQ-018 Opcodes: 0000 A<=A+imm; 0001 A<=B; 0010 A<=inp; 0011 A<=imm; 0100 B<=A; 0101 B<=B+imm; 0110 B<=inp; 0111 B<=imm.
REQ-019 Opcodes: 1001 outp<=B; 1010 outp<=A; 1011 outp<=imm; 1000 HALT; 1101 NOP.
REQ-020 Opcodes: 1111 JMP PC<=imm[AW-1:0]; 1110 JNC jump if cflag=0; 1100 JC jump if cflag=1.
REQ-021 Addition is modulo 2^DW; cflag<=carry-out of the DW-bit add.
REQ-022 Every executed instruction other than ADD (0000, 0101) clears cflag, including taken and untaken jumps, HALT and NOP.
REQ-023 Non-jump and untaken jumps: PC<=PC+1 modulo 2^AW (PC at all ones wraps to 0).
REQ-024 inp is sampled in the EXEC cycle only.
REQ-025 out_valid=1 during exactly the cycle after the EXEC of 1001/1010/1011, coincident with the new outp value; 0 otherwise.
REQ-026 HALT: imem_req=0, halted=1, no state change; exit only via reset.
REQ-027 imem_ack while imem_req=0 is ignored.

Reset
REQ-028 On reset assertion, regardless of clk: state=FETCH, PC=0, A=0, B=0, IR=0, cflag=0, outp=0, out_valid=0, halted=0.
REQ-029 After reset deassertion, imem_req=1 with imem_addr=0 in the first cycle.
REQ-030 Reset asserted mid-fetch (imem_req=1) drops any pending fetch; no stale IR is executed.

Verification
REQ-031 Reset, then program {0011_0011, 0000_0101, 1010_0000, 1000_0000} (DW=4), zero-wait ack -> outp=1000 with one out_valid pulse, cflag=0, halted=1.
REQ-032 A=1111, execute 0000_0001 then 1110_0111 -> A=0000, cflag=1 after ADD, JNC not taken (PC=2), cflag=0 after JNC.
REQ-033 imem_ack held low 5 cycles in FETCH -> imem_req and imem_addr stay constant, A/B/PC unchanged; executes on the first acked edge.
REQ-034 AW=4, NOP at address 15 -> next imem_addr=0.
REQ-035 inp=1010, execute 0110_xxxx, 1001_xxxx -> B=1010, outp=1010, out_valid pulse of exactly 1 cycle.
REQ-036 Assert reset asynchronously mid-EXEC with A=0101, outp=0011 -> all outputs return to REQ-028 values before the next clk edge.
